// File: rtl/dcfifo_s_pkg.sv
// Shared helpers for the dcfifo_s dual-clock FIFO: gray/binary pointer
// conversion and the attribute string that tags synchronizer flops.
package dcfifo_s_pkg;

    localparam int PTR_MAX_W = 32;
    localparam string SYNC_ATTR = "-name SYNCHRONIZER_IDENTIFICATION FORCED";

    // Narrower pointers are zero-extended into PTR_MAX_W and the result is
    // truncated back, so one body serves every pointer width.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/dcfifo_s_rd_ctrl_if.sv
// Read-side bundle of dcfifo_s: pointer exchange with the write side, the
// storage read port and the show-ahead consumer handshake.
interface dcfifo_s_rd_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  re;
    logic [WIDTH-1:0]      mem_dout;
    logic [WIDTH-1:0]      dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [ADDR_WIDTH:0]   rd_used;

    modport master (
        input  wptr_gray, mem_dout, dout_ready,
        output rptr_gray, raddr, re, dout, dout_valid, rd_used
    );

    modport slave (
        output wptr_gray, mem_dout, dout_ready,
        input  rptr_gray, raddr, re, dout, dout_valid, rd_used
    );
endinterface

// File: rtl/dcfifo_s_ptr_sync.sv
// Multi-flop synchronizer for a gray-coded pointer crossing into clk, followed
// by conversion back to binary. Shared by both sides of dcfifo_s.
module dcfifo_s_ptr_sync
    import dcfifo_s_pkg::*;
#(
    parameter int PTR_W       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PTR_W-1:0] i_gray,
    output logic [PTR_W-1:0] o_bin
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("dcfifo_s_ptr_sync: SYNC_STAGES must be 2..4");
    end

    (* altera_attribute = SYNC_ATTR *) logic [PTR_W-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_bin = PTR_W'(gray2bin(PTR_MAX_W'(r_sync[SYNC_STAGES-1])));

endmodule

// File: rtl/dcfifo_s_rd_ctrl.sv
// Read-side controller of dcfifo_s: issues storage reads, hides the storage's
// one-cycle read latency behind a two-entry show-ahead buffer.
module dcfifo_s_rd_ctrl
    import dcfifo_s_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               rclk,
    input  logic               rst_n,
    dcfifo_s_rd_ctrl_if.master bus
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]    w_wbin_s;
    logic [PW-1:0]    w_rptr_next;
    logic             w_empty;
    logic             w_re;
    logic             w_pop;
    logic [1:0]       w_occ;
    logic [2:0]       w_budget;
    logic             w_out_from_skid;
    logic             w_out_from_mem;
    logic             w_skid_from_mem;

    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    r_rptr_gray;
    logic             r_inflight_p1;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [WIDTH-1:0] r_skid;
    logic             r_skid_valid;

    dcfifo_s_ptr_sync #(
        .PTR_W       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk    (rclk),
        .rst_n  (rst_n),
        .i_gray (bus.wptr_gray),
        .o_bin  (w_wbin_s)
    );

    // Stage p0: issue. A read is allowed only if the word it returns will
    // still find a free buffer slot after this cycle's pop.
    assign w_empty     = (r_rptr == w_wbin_s);
    assign w_pop       = r_dout_valid & bus.dout_ready;
    assign w_occ       = {1'b0, r_dout_valid} + {1'b0, r_skid_valid};
    assign w_budget    = {1'b0, w_occ} + {2'b00, r_inflight_p1} - {2'b00, w_pop};
    assign w_re        = ~w_empty & (w_budget < 3'd2);
    assign w_rptr_next = r_rptr + {{ADDR_WIDTH{1'b0}}, w_re};

    // Stage p1: storage data arrives; the skid word always precedes it.
    assign w_out_from_skid = w_pop & r_skid_valid;
    assign w_out_from_mem  = r_inflight_p1 & (~r_dout_valid | (w_pop & ~r_skid_valid));
    assign w_skid_from_mem = r_inflight_p1 & ~w_out_from_mem;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr        <= '0;
            r_rptr_gray   <= '0;
            r_inflight_p1 <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_skid_valid  <= 1'b0;
        end else begin
            r_rptr        <= w_rptr_next;
            r_rptr_gray   <= PW'(bin2gray(PTR_MAX_W'(w_rptr_next)));
            r_inflight_p1 <= w_re;

            if (w_out_from_skid) begin
                r_dout <= r_skid;
            end else if (w_out_from_mem) begin
                r_dout <= bus.mem_dout;
            end

            if (w_out_from_skid || w_out_from_mem) begin
                r_dout_valid <= 1'b1;
            end else if (w_pop) begin
                r_dout_valid <= 1'b0;
            end

            if (w_skid_from_mem) begin
                r_skid_valid <= 1'b1;
            end else if (w_out_from_skid) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (w_skid_from_mem) begin
            r_skid <= bus.mem_dout;
        end
    end

    assign bus.re         = w_re;
    assign bus.raddr      = r_rptr[ADDR_WIDTH-1:0];
    assign bus.rptr_gray  = r_rptr_gray;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.rd_used    = w_wbin_s - r_rptr;

endmodule
